otter_mem_arbiter: RTL
======================

# otter_mem_arbiter

Shares the single unified OTTER memory port between the pipeline's instruction-fetch requester and its data (load/store) requester. Issues at most one access per cycle and gives data accesses priority, with a starvation guard that forces a fetch grant after a bounded run of data grants. Tracks in-flight reads through a fixed-latency tag pipeline and routes each read response back to its owner in order. Sits between the IF/MEM stages and the memory module.

## Interface
- RD_LAT, 1: memory read latency in cycles from accepting edge to valid M_RDATA (legal 1..4)
- MAX_STARVE, 4: consecutive data grants allowed while a fetch waits (legal 1..15)

- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IF_REQ  in  1  fetch request; held until granted
- IF_ADDR  in  32  fetch word address
- IF_GNT  out  1  fetch accepted this cycle
- IF_RVALID  out  1  fetch data valid this cycle
- IF_RDATA  out  32  fetch data
- D_REQ  in  1  data request; held until granted
- D_WE  in  1  1 = store, 0 = load
- D_ADDR, D_WDATA  in  32  data address / store data
- D_SIZE  in  2  access size; D_SIGN  in  1  load sign-extend
- D_GNT  out  1  data access accepted this cycle
- D_RVALID  out  1  load data valid this cycle
- D_RDATA  out  32  load data
- M_RD, M_WE  out  1  memory read / write strobe
- M_ADDR, M_WDATA  out  32; M_SIZE  out  2; M_SIGN  out  1
- M_RDATA  in  32  memory read data

## Operation
- Accept = REQ & GNT in a cycle; accepted request's fields drive M_* combinationally in that cycle.
- Arbitration (combinational from REQ and registered state):
  - D_REQ only: D_GNT=1. IF_REQ only: IF_GNT=1. Neither: M_RD=M_WE=0, M_ADDR=0.
  - Both: data wins unless starve_cnt == MAX_STARVE, then fetch wins.
  - IF_GNT and D_GNT never both 1.
- starve_cnt (4 bits): increments on each data accept while IF_REQ=1; clears on any fetch accept or when IF_REQ=0; saturates at MAX_STARVE.
- State (last_owner): OWN_NONE, OWN_IF, OWN_DATA; updated each edge to the accepted owner or OWN_NONE. Informational output for debug under macro; no effect on arbitration.
- Fetch accept: M_RD=1, M_SIZE=2'b10, M_SIGN=0. Data load: M_RD=1. Store: M_WE=1, M_RD=0; no response.
- Tag pipeline: RD_LAT stages of {valid, owner}; stage 0 loaded on each read accept, shifts every cycle unconditionally. Final stage valid with owner IF -> IF_RVALID=1; DATA -> D_RVALID=1.
- IF_RDATA and D_RDATA both equal M_RDATA; consumers qualify with RVALID.

## Timing
- Grant latency 0 cycles (same cycle as request when winning). Read response exactly RD_LAT cycles after accepting edge; one response per cycle max, in issue order.
- Back-to-back accepts every cycle allowed; no bubbles inserted.
- Reset (async assert, sync deassert by system): starve_cnt=0, last_owner=OWN_NONE, all tag stages invalid; IF_RVALID=D_RVALID=0 immediately. Grants are combinational and follow REQ once out of reset; held low during reset.
- Reset mid-operation: in-flight reads dropped, no RVALID generated for them.
- Simultaneous starvation release and data request: fetch granted, data held; next cycle data granted (starve_cnt now 0).
- Store followed by load to same address on consecutive cycles: ordering preserved by memory port order.

## Configuration
- OTTER_ARB_DEBUG_EN defined: extra outputs DBG_OWNER (2 bits, last_owner) and DBG_STARVE (4 bits, starve_cnt), plus an assertion that IF_GNT & D_GNT never both 1 and that a final-stage valid never coincides with reset. Undefined: ports and assertions absent; arbitration identical.

## Structure
- Package otter_arb_pkg: owner_t enum (OWN_NONE, OWN_IF, OWN_DATA), tag_t struct {valid, owner}, size constant SIZE_WORD=2'b10.
- Sub-module arb_tag_pipe: parameterised RD_LAT-deep shift register of tag_t with async active-low clear; arbiter instantiates one.

## Test plan
- IF_REQ only, IF_ADDR=0x100, RD_LAT=1 -> IF_GNT=1 same cycle, M_RD=1 M_ADDR=0x100, IF_RVALID=1 next cycle with M_RDATA.
- IF_REQ and D_REQ (load 0x2000) held continuously, MAX_STARVE=4 -> 4 data grants, 1 fetch grant, repeating; no overlap of grants.
- Store D_WE=1 addr 0x3000 data 0xDEADBEEF -> M_WE=1 M_WDATA=0xDEADBEEF, no D_RVALID ever.
- RD_LAT=3, alternating fetch/load accepts 4 cycles -> RVALID pattern IF,D,IF,D starting 3 cycles after first accept.
- RESET_N low one cycle after two reads accepted, RD_LAT=2 -> no RVALID observed; starve_cnt=0 after release.
- Idle (no REQ) 10 cycles -> M_RD=M_WE=0, both GNT and RVALID 0.

Source files
------------

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory-port arbiter.
// Used by otter_mem_arbiter and arb_tag_pipe.
package otter_arb_pkg;

    // Owner of a memory access; also the debug view of the last accepted owner.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    // One in-flight read slot: whether it carries a response and who gets it.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    // Instruction fetches are always full-word, unsigned.
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam tag_t TAG_EMPTY = '{valid: 1'b0, owner: OWN_NONE};

    // Build the tag pushed into the pipeline for a cycle's accepted access.
    function automatic tag_t make_tag(input logic is_read, input logic is_fetch);
        tag_t t;
        t = TAG_EMPTY;
        if (is_read) begin
            t.valid = 1'b1;
            t.owner = is_fetch ? OWN_IF : OWN_DATA;
        end
        return t;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of read tags. Stage 0 captures the tag of the
// access accepted this cycle; every stage shifts on every clock, so the
// final stage presents the tag of the read issued DEPTH cycles earlier.
// Asynchronous active-low clear drops all in-flight reads.
module arb_tag_pipe
    import otter_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t load_tag,
    output tag_t final_tag
);

    tag_t [DEPTH-1:0] stages;

    if (DEPTH == 1) begin : g_single
        // Single stage: capture the current tag every edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stages <= '0;
            end else begin
                stages <= load_tag;
            end
        end
    end else begin : g_shift
        // Multi-stage: shift toward the top, new tag enters at stage 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stages <= '0;
            end else begin
                stages <= {stages[DEPTH-2:0], load_tag};
            end
        end
    end

    assign final_tag = stages[DEPTH-1];

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing the unified OTTER memory port between instruction fetch
// and data load/store. Data wins by default; after MAX_STARVE consecutive
// data grants with a fetch waiting, the fetch is forced through. Reads are
// tracked through an RD_LAT-deep tag pipeline so each response is routed
// back to its owner in issue order.
//
// Optional build macro: OTTER_ARB_DEBUG_EN adds DBG_OWNER / DBG_STARVE
// outputs and runtime assertions on grant exclusivity and reset behaviour.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    // Fetch requester
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_RVALID,
    output logic [31:0] IF_RDATA,
    // Data requester
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,
    // Memory port
    output logic        M_RD,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic [31:0] M_RDATA
`ifdef OTTER_ARB_DEBUG_EN
    ,
    output logic [1:0]  DBG_OWNER,
    output logic [3:0]  DBG_STARVE
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       starve_hit;
    logic       if_gnt;
    logic       d_gnt;
    logic       if_acc;
    logic       d_acc;
    logic       rd_acc;
    tag_t       load_tag;
    tag_t       final_tag;

    // Grant decision: data priority, fetch forced once the starvation limit is hit.
    // Grants are held low while reset is asserted.
    always_comb begin
        starve_hit = (starve_q == STARVE_LIM);
        if_gnt     = RESET_N & IF_REQ & (~D_REQ | starve_hit);
        d_gnt      = RESET_N & D_REQ & ~(IF_REQ & starve_hit);
        if_acc     = IF_REQ & if_gnt;
        d_acc      = D_REQ & d_gnt;
        rd_acc     = if_acc | (d_acc & ~D_WE);
    end

    assign IF_GNT = if_gnt;
    assign D_GNT  = d_gnt;

    // Starvation counter next state: counts data wins over a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (!IF_REQ || if_acc) begin
            starve_d = 4'd0;
        end else if (d_acc && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory port mux: the accepted request's fields drive the port this cycle.
    always_comb begin
        M_RD    = 1'b0;
        M_WE    = 1'b0;
        M_ADDR  = 32'd0;
        M_WDATA = 32'd0;
        M_SIZE  = 2'b00;
        M_SIGN  = 1'b0;
        if (if_acc) begin
            M_RD   = 1'b1;
            M_ADDR = IF_ADDR;
            M_SIZE = SIZE_WORD;
        end else if (d_acc) begin
            M_RD    = ~D_WE;
            M_WE    = D_WE;
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
            M_SIZE  = D_SIZE;
            M_SIGN  = D_SIGN;
        end
    end

    // Tag for this cycle's read (stores and idle cycles push an empty slot).
    always_comb begin
        load_tag = make_tag(rd_acc, if_acc);
    end

    arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .load_tag  (load_tag),
        .final_tag (final_tag)
    );

    // Response routing: the final-stage tag selects which requester sees valid.
    always_comb begin
        IF_RVALID = final_tag.valid & (final_tag.owner == OWN_IF);
        D_RVALID  = final_tag.valid & (final_tag.owner == OWN_DATA);
        IF_RDATA  = M_RDATA;
        D_RDATA   = M_RDATA;
    end

`ifdef OTTER_ARB_DEBUG_EN
    owner_t last_owner_q;
    owner_t last_owner_d;

    // Last-owner state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_owner_q <= OWN_NONE;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    // Last-owner next state: whoever was accepted this cycle, else none.
    always_comb begin
        last_owner_d = OWN_NONE;
        if (if_acc) begin
            last_owner_d = OWN_IF;
        end else if (d_acc) begin
            last_owner_d = OWN_DATA;
        end
    end

    // Debug outputs.
    always_comb begin
        DBG_OWNER  = last_owner_q;
        DBG_STARVE = starve_q;
    end

    a_one_grant : assert property (@(posedge CLK) !(IF_GNT && D_GNT))
        else $error("both grants asserted");

    a_no_resp_in_reset : assert property (@(posedge CLK) !RESET_N |-> !final_tag.valid)
        else $error("read response during reset");
`endif

endmodule
